// File: rtl/decode_operand_stage_pkg.sv
// decode_operand_stage_pkg: RV32I opcodes, decoded-field struct and decode helper shared by the decode stage and the ALU
package decode_operand_stage_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm_i;
        logic [19:0] imm_u;
        logic [4:0]  rs1f;
        logic [4:0]  rs2f;
        logic        use_rs1;
        logic        use_rs2;
        logic        pc_rs1;
        logic        illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        logic is_r, is_i, is_b;
        is_r      = instr[6:0] == OP_R;
        is_i      = instr[6:0] == OP_I;
        is_b      = instr[6:0] == OP_B;
        d.opcode  = instr[6:0];
        d.funct3  = instr[14:12];
        d.imm_i   = instr[31:20];
        d.imm_u   = instr[31:12];
        d.rs1f    = instr[19:15];
        d.rs2f    = instr[24:20];
        d.use_rs1 = is_r | is_i | is_b;
        d.use_rs2 = is_r | is_b;
        d.pc_rs1  = instr[6:0] == OP_AUIPC;
        d.illegal = !(d.use_rs1 | d.pc_rs1 | instr[6:0] == OP_LUI);
        d.funct7  = (is_r | d.illegal | (is_i & instr[13:12] == 2'b01)) ? instr[31:25] : 7'd0;
        return d;
    endfunction

endpackage

// File: rtl/decode_operand_stage_regfile.sv
// regfile_2r1w: async-reset 2-read/1-write register file, x0 reads zero, write-through on read/write collision
module regfile_2r1w
    import decode_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr1,
    input  logic [AW-1:0]         raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] mem [REG_COUNT];
    logic                  wr;

    assign wr = we && waddr != '0;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        else if (wr)
            mem[waddr] <= wdata;

    always_comb begin
        rdata1 = raddr1 == '0 ? '0 : (wr && waddr == raddr1) ? wdata : mem[raddr1];
        rdata2 = raddr2 == '0 ? '0 : (wr && waddr == raddr2) ? wdata : mem[raddr2];
    end

endmodule

// File: rtl/decode_operand_stage.sv
// decode_operand_stage: RV32I decode/operand fetch; in_* handshake -> regfile read -> registered ALU fields on out_*, wb_* writes regfile
module decode_operand_stage
    import decode_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 7,
    parameter int FUNCT3_LENGTH = 3,
    parameter int FUNCT7_LENGTH = 7,
    parameter int REG_COUNT     = 32,
    localparam int AW           = $clog2(REG_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    rs1,
    output logic [DATA_WIDTH-1:0]    rs2,
    output logic [OPCODE_LENGTH-1:0] Opcode,
    output logic [FUNCT3_LENGTH-1:0] Funct3,
    output logic [FUNCT7_LENGTH-1:0] Funct7,
    output logic [11:0]              immI,
    output logic [19:0]              immU,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic                     out_illegal,
    output logic [31:0]              instr_count
);

    dec_t                  d;
    logic                  accept, held, wb_live, hit1, hit2;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic [AW-1:0]         h_rs1f, h_rs2f;
    logic                  h_use1, h_use2;

    assign d        = decode(in_instr);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign held     = out_valid && !out_ready;
    assign wb_live  = wb_en && wb_addr != '0;
    assign hit1     = wb_live && h_use1 && wb_addr == h_rs1f;
    assign hit2     = wb_live && h_use2 && wb_addr == h_rs2f;

    regfile_2r1w #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
        .clock  (clock),
        .reset_n(reset_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (AW'(d.rs1f)),
        .raddr2 (AW'(d.rs2f)),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            out_valid   <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            Opcode      <= '0;
            Funct3      <= '0;
            Funct7      <= '0;
            immI        <= '0;
            immU        <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            instr_count <= '0;
            h_rs1f      <= '0;
            h_rs2f      <= '0;
            h_use1      <= 1'b0;
            h_use2      <= 1'b0;
        end else begin
            out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
            if (accept) begin
                rs1         <= d.use_rs1 ? rd1 : d.pc_rs1 ? in_pc : '0;
                rs2         <= d.use_rs2 ? rd2 : '0;
                Opcode      <= d.opcode;
                Funct3      <= d.funct3;
                Funct7      <= d.funct7;
                immI        <= d.imm_i;
                immU        <= d.imm_u;
                out_pc      <= in_pc;
                out_illegal <= d.illegal;
                instr_count <= instr_count + 32'd1;
                h_rs1f      <= AW'(d.rs1f);
                h_rs2f      <= AW'(d.rs2f);
                h_use1      <= d.use_rs1;
                h_use2      <= d.use_rs2;
            end else if (held) begin
                // a writeback landing while the ALU stalls must not leave a stale operand behind
                if (hit1) rs1 <= wb_data;
                if (hit2) rs2 <= wb_data;
            end
        end

endmodule

// File: tb/tb_decode_operand_stage.sv
// tb_decode_operand_stage: directed self-checking bench for decode_operand_stage
module tb_decode_operand_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, wb_data, rs1, rs2, out_pc, instr_count;
    logic [4:0]  wb_addr;
    logic [6:0]  Opcode, Funct7;
    logic [2:0]  Funct3;
    logic [11:0] immI;
    logic [19:0] immU;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] ADD_X1_X2  = 32'h002081B3;
    localparam logic [31:0] ADD_X0_X0  = 32'h000001B3;
    localparam logic [31:0] ADDI_F7    = 32'h02500093;
    localparam logic [31:0] SRAI       = 32'h40215093;
    localparam logic [31:0] AUIPC      = 32'h12345297;
    localparam logic [31:0] LUI        = 32'h123450B7;
    localparam logic [31:0] BEQ_NEG    = 32'hFE208EE3;
    localparam logic [31:0] ILLEGAL    = 32'h0020807F;

    always #5 clock = ~clock;

    decode_operand_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .Opcode     (Opcode),
        .Funct3     (Funct3),
        .Funct7     (Funct7),
        .immI       (immI),
        .immU       (immU),
        .out_pc     (out_pc),
        .out_illegal(out_illegal),
        .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] v);
        wb_en = 1'b1; wb_addr = a; wb_data = v;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst rs1", rs1, 0);
        check("rst count", instr_count, 0);
        check("rst in_ready", 32'(in_ready), 1);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd10);

        issue(ADD_X1_X2, 32'h40);
        check("add valid", 32'(out_valid), 1);
        check("add rs1", rs1, 5);
        check("add rs2", rs2, 10);
        check("add opcode", 32'(Opcode), 32'h33);
        check("add funct7", 32'(Funct7), 0);
        check("add count", instr_count, 1);
        check("add pc", out_pc, 32'h40);

        issue(ADDI_F7, 32'h44);
        check("addi immI", 32'(immI), 32'h025);
        check("addi rs1", rs1, 0);
        check("addi rs2", rs2, 0);
        check("addi funct7", 32'(Funct7), 0);

        issue(SRAI, 32'h48);
        check("srai funct7", 32'(Funct7), 32'h20);
        check("srai funct3", 32'(Funct3), 5);
        check("srai rs1", rs1, 10);

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h8000_0000;
        issue(ADD_X1_X2, 32'h4C);
        wb_en = 1'b0;
        check("bypass rs1", rs1, 32'h8000_0000);
        check("bypass rs2", rs2, 10);
        check("bypass count", instr_count, 4);

        out_ready = 1'b0;
        wb(5'd2, 32'h55);
        check("hold rs2", rs2, 32'h55);
        check("hold rs1 kept", rs1, 32'h8000_0000);
        wb(5'd1, 32'h1234);
        check("hold rs1", rs1, 32'h1234);
        check("hold valid", 32'(out_valid), 1);

        in_valid = 1'b1; in_instr = LUI; in_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            check("stall in_ready", 32'(in_ready), 0);
            tick();
            check("stall opcode", 32'(Opcode), 32'h33);
            check("stall pc", out_pc, 32'h4C);
            check("stall count", instr_count, 4);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush hold", 32'(out_valid), 0);
        check("flush count", instr_count, 4);
        in_valid = 1'b0; out_ready = 1'b1;

        flush = 1'b1;
        issue(ADD_X1_X2, 32'h50);
        flush = 1'b0;
        check("flush accept", 32'(out_valid), 0);
        check("flush acc count", instr_count, 4);

        wb(5'd0, 32'hDEAD_BEEF);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        issue(ADD_X0_X0, 32'h54);
        wb_en = 1'b0;
        check("x0 rs1", rs1, 0);
        check("x0 rs2", rs2, 0);
        check("x0 count", instr_count, 5);

        issue(AUIPC, 32'h100);
        check("auipc rs1", rs1, 32'h100);
        check("auipc rs2", rs2, 0);
        check("auipc immU", 32'(immU), 32'h12345);
        check("auipc illegal", 32'(out_illegal), 0);

        issue(LUI, 32'h104);
        check("lui rs1", rs1, 0);
        check("lui immU", 32'(immU), 32'h12345);
        check("lui opcode", 32'(Opcode), 32'h37);

        issue(BEQ_NEG, 32'h108);
        check("b rs1", rs1, 32'h1234);
        check("b rs2", rs2, 32'h55);
        check("b funct7", 32'(Funct7), 0);

        issue(ILLEGAL, 32'h10C);
        check("ill flag", 32'(out_illegal), 1);
        check("ill opcode", 32'(Opcode), 32'h7F);
        check("ill rs1", rs1, 0);
        check("ill rs2", rs2, 0);
        check("ill count", instr_count, 9);

        out_ready = 1'b0;
        issue(ADD_X1_X2, 32'h110);
        check("pre-rst valid", 32'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async valid", 32'(out_valid), 0);
        check("async count", instr_count, 0);
        check("async rs1", rs1, 0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(ADD_X1_X2, 32'h114);
        check("post-rst rs1", rs1, 0);
        check("post-rst rs2", rs2, 0);
        check("post-rst count", instr_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
